// File: rtl/uart_bus_ctrl_pkg.sv
// Shared types and constants for the UART-to-bus command sequencer.
package uart_bus_ctrl_pkg;

  // Frame parser / transaction sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_H,
    ST_A_L,
    ST_D_H,
    ST_D_L,
    ST_BUS,
    ST_TX
  } state_t;

  // Transmit handshake states of the response sender.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_RISE,
    TX_WAIT_FALL
  } tx_state_t;

  // Default opcode bytes that open a host frame.
  localparam logic [7:0] OPC_WR = 8'h80;
  localparam logic [7:0] OPC_RD = 8'h40;

  // Response bytes: write completed / bus acknowledge timed out.
  localparam logic [7:0] RSP_OK = 8'hAA;
  localparam logic [7:0] RSP_TO = 8'hEE;

endpackage

// File: rtl/uart_bus_ctrl_if.sv
// Strobe/ack bus between the command sequencer (master) and the IO hub (slave).
interface uart_bus_ctrl_if;
  logic        stb_o;
  logic        we_o;
  logic [15:0] addr_o;
  logic [15:0] dat_o;
  logic        ack_i;
  logic [15:0] dat_i;

  modport master (output stb_o, we_o, addr_o, dat_o, input ack_i, dat_i);
  modport slave  (input stb_o, we_o, addr_o, dat_o, output ack_i, dat_i);
endinterface

// File: rtl/uart_bus_ctrl_tx_seq.sv
// Sends a one- or two-byte response through the UART transmitter, waiting for
// each byte's is_transmitting rise and fall before launching the next one.
module uart_tx_seq
  import uart_bus_ctrl_pkg::*;
(
  input  logic       clk_cmt,
  input  logic       rst,
  input  logic       start,
  input  logic       two_bytes,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic       is_transmitting,
  output logic       transmit,
  output logic [7:0] tx_byte,
  output logic       done
);

  tx_state_t  st_q, st_d;
  logic       more_q, more_d;
  logic       transmit_q, transmit_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] cur_q, cur_d;
  logic [7:0] nxt_q, nxt_d;

  // Next-state and output decode of the transmit handshake.
  always_comb begin
    st_d       = st_q;
    more_d     = more_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    done       = 1'b0;
    case (st_q)
      TX_IDLE: begin
        if (start) begin
          cur_d  = byte0;
          nxt_d  = byte1;
          more_d = two_bytes;
          st_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!is_transmitting) begin
          transmit_d = 1'b1;
          tx_byte_d  = cur_q;
          st_d       = TX_WAIT_RISE;
        end
      end
      TX_WAIT_RISE: begin
        if (is_transmitting) st_d = TX_WAIT_FALL;
      end
      TX_WAIT_FALL: begin
        if (!is_transmitting) begin
          if (more_q) begin
            cur_d  = nxt_q;
            more_d = 1'b0;
            st_d   = TX_SEND;
          end else begin
            done = 1'b1;
            st_d = TX_IDLE;
          end
        end
      end
      default: st_d = TX_IDLE;
    endcase
  end

  // Control and visible outputs; cleared by reset.
  always_ff @(posedge clk_cmt) begin
    if (rst) begin
      st_q       <= TX_IDLE;
      more_q     <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      st_q       <= st_d;
      more_q     <= more_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  // Pending response bytes; only read after being loaded on start.
  always_ff @(posedge clk_cmt) begin
    cur_q <= cur_d;
    nxt_q <= nxt_d;
  end

  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;

endmodule

// File: rtl/uart_bus_ctrl.sv
// Parses host frames from the UART into single bus reads/writes, runs the
// strobe/ack handshake with byte and ack timeouts, and reports the result.
module uart_bus_ctrl
  import uart_bus_ctrl_pkg::*;
#(
  parameter int unsigned BYTE_TO = 100000,
  parameter int unsigned ACK_TO  = 255,
  parameter logic [7:0]  OP_WR   = OPC_WR,
  parameter logic [7:0]  OP_RD   = OPC_RD
) (
  input  logic            clk_cmt,
  input  logic            rst,
  input  logic            received,
  input  logic [7:0]      rx_byte,
  input  logic            recv_error,
  input  logic            is_transmitting,
  output logic            transmit,
  output logic [7:0]      tx_byte,
  uart_bus_ctrl_if.master bus,
  output logic            busy,
  output logic [7:0]      err_cnt
);

  localparam int unsigned BT_W = $clog2(BYTE_TO + 1);
  localparam int unsigned AT_W = $clog2(ACK_TO + 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TO - 1);
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(ACK_TO - 1);

  state_t          state_q, state_d;
  logic [BT_W-1:0] byte_tmr_q, byte_tmr_d;
  logic [AT_W-1:0] ack_tmr_q, ack_tmr_d;
  logic            is_wr_q, is_wr_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     dat_q, dat_d;
  logic [7:0]      err_q, err_d;

  logic            tx_start;
  logic            tx_two;
  logic [7:0]      tx_b0;
  logic [7:0]      tx_b1;
  logic            tx_done;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Frame parsing, bus handshake and timeout decisions.
  always_comb begin
    state_d    = state_q;
    byte_tmr_d = byte_tmr_q;
    ack_tmr_d  = '0;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    err_d      = err_q;
    tx_start   = 1'b0;
    tx_two     = 1'b0;
    tx_b0      = RSP_OK;
    tx_b1      = 8'h00;
    case (state_q)
      ST_IDLE: begin
        byte_tmr_d = '0;
        if (recv_error) begin
          err_d = sat_inc(err_q);
        end else if (received && (rx_byte == OP_WR || rx_byte == OP_RD)) begin
          is_wr_d = (rx_byte == OP_WR);
          state_d = ST_A_H;
        end
      end
      ST_A_H, ST_A_L, ST_D_H, ST_D_L: begin
        if (recv_error) begin
          err_d      = sat_inc(err_q);
          byte_tmr_d = '0;
          state_d    = ST_IDLE;
        end else if (received) begin
          byte_tmr_d = '0;
          if (state_q == ST_A_H) begin
            addr_d[15:8] = rx_byte;
            state_d      = ST_A_L;
          end else if (state_q == ST_A_L) begin
            addr_d[7:0] = rx_byte;
            state_d     = is_wr_q ? ST_D_H : ST_BUS;
          end else if (state_q == ST_D_H) begin
            dat_d[15:8] = rx_byte;
            state_d     = ST_D_L;
          end else begin
            dat_d[7:0] = rx_byte;
            state_d    = ST_BUS;
          end
        end else if (byte_tmr_q == BT_LAST) begin
          err_d      = sat_inc(err_q);
          byte_tmr_d = '0;
          state_d    = ST_IDLE;
        end else begin
          byte_tmr_d = byte_tmr_q + BT_W'(1);
        end
      end
      ST_BUS: begin
        if (bus.ack_i) begin
          tx_start = 1'b1;
          state_d  = ST_TX;
          if (!is_wr_q) begin
            tx_two = 1'b1;
            tx_b0  = bus.dat_i[15:8];
            tx_b1  = bus.dat_i[7:0];
          end
        end else if (ack_tmr_q == AT_LAST) begin
          err_d    = sat_inc(err_q);
          tx_start = 1'b1;
          tx_b0    = RSP_TO;
          state_d  = ST_TX;
        end else begin
          ack_tmr_d = ack_tmr_q + AT_W'(1);
        end
      end
      ST_TX: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; every output-visible value clears on reset.
  always_ff @(posedge clk_cmt) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_tmr_q <= '0;
      ack_tmr_q  <= '0;
      is_wr_q    <= 1'b0;
      addr_q     <= 16'h0000;
      dat_q      <= 16'h0000;
      err_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      byte_tmr_q <= byte_tmr_d;
      ack_tmr_q  <= ack_tmr_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
    end
  end

  uart_tx_seq u_tx_seq (
    .clk_cmt         (clk_cmt),
    .rst             (rst),
    .start           (tx_start),
    .two_bytes       (tx_two),
    .byte0           (tx_b0),
    .byte1           (tx_b1),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .done            (tx_done)
  );

  assign bus.stb_o  = (state_q == ST_BUS);
  assign bus.we_o   = is_wr_q;
  assign bus.addr_o = addr_q;
  assign bus.dat_o  = dat_q;
  assign busy       = (state_q != ST_IDLE);
  assign err_cnt    = err_q;

endmodule
